// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and DM.
// DM has priority, IF starvation is bounded, and hung accesses time out.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_rdata/if_ready   fetched word and one-cycle completion pulse
//   dm_req/dm_we        data request and store select
//   dm_addr/dm_wdata    data address and store data
//   dm_be               store byte enables
//   dm_rdata/dm_ready   load data and one-cycle completion pulse
//   mem_req/mem_we      memory strobe and write enable
//   mem_addr/mem_wdata  memory address and write data
//   mem_be              memory byte enables
//   mem_rdata/mem_ready memory read data and completion
//   bus_err             sticky timeout flag
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] S_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        bus_err_q, bus_err_d;

    logic if_elig;
    logic dm_elig;
    logic grant_dm;
    logic grant_if;
    logic [31:0] rd_val;

    // A requester in its ready cycle still holds req; mask it
    assign if_elig  = if_req & ~if_ready_q;
    assign dm_elig  = dm_req & ~dm_ready_q;
    assign grant_dm = dm_elig & (~if_elig | (streak_q < S_MAX));
    assign grant_if = if_elig & ~grant_dm;
    // Stores return zero as read data
    assign rd_val   = mem_we_q ? 32'h0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = 32'h0;
        dm_rdata_d  = 32'h0;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        bus_err_d   = bus_err_q;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                unique case (1'b1)
                    grant_dm: begin
                        state_d     = DM_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                        if (!if_req)
                            streak_d = '0;
                        else if (streak_q != S_MAX)
                            streak_d = streak_q + 1'b1;
                    end
                    grant_if: begin
                        state_d     = IF_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'h0;
                        mem_be_d    = 4'hF;
                        streak_d    = '0;
                    end
                    default: ;
                endcase
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready || tcnt_q == T_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    tcnt_d    = '0;
                    if (!mem_ready)
                        bus_err_d = 1'b1;
                    if (state_q == IF_BUSY) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_ready ? rd_val : 32'h0;
                    end else begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = mem_ready ? rd_val : 32'h0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            streak_q    <= '0;
            tcnt_q      <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between instruction fetch (IF) and the data-memory stage (DM) of the pipelined RISC-V core.
- Sequences each access with a request/ready handshake to the memory, tolerating variable memory latency.
- Drives the per-stage ready pulses that the pipeline uses to stall.
- Gives DM priority, bounds IF starvation with a streak limit, and aborts hung accesses with a timeout.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive DM grants while an IF request is pending; must be at least 1.
- TIMEOUT, 16: number of busy cycles without mem_ready before the access is aborted; must be at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid only while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_be  in  4  store byte enables.
- dm_rdata  out  32  load data; valid only while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for the data access.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion, sampled only while mem_req=1.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=1 at a clock edge) forces the following. This applies even mid-transaction, and any in-flight access is dropped with no ready pulse.
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
  - streak=0, tcnt=0, bus_err=0.
- All outputs are registered.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitration, evaluated each cycle:
  - A requester whose ready output is 1 in the current cycle is masked; this prevents a duplicate grant of a just-completed request.
  - Only DM eligible: grant DM.
  - Only IF eligible: grant IF.
  - Both eligible and streak < MAX_DATA_STREAK: grant DM.
  - Both eligible and streak == MAX_DATA_STREAK: grant IF.
- On a grant:
  - Register the address, we, wdata and be into the mem_* outputs and set mem_req=1 on the next edge.
  - An IF grant forces mem_we=0 and mem_be=4'b1111.
- Streak counter:
  - Increments on a DM grant when if_req=1 at the grant cycle, saturating at MAX_DATA_STREAK.
  - Clears on an IF grant, and on a DM grant when if_req=0.
- Busy states:
  - mem_req and all mem_* outputs are held stable.
  - Requester inputs are not resampled; a requester dropping req mid-access does not cancel it.
- Completion: on mem_ready=1 in IF_BUSY or DM_BUSY:
  - mem_req goes to 0.
  - The owner's rdata is loaded with mem_rdata; stores load 0.
  - The owner's ready goes to 1 for exactly one cycle.
  - state returns to IDLE and tcnt clears.
- Latency: grant at edge 0, so mem_req=1 in cycle 1. If mem_ready is first seen in cycle k, ready=1 in cycle k+1. With a zero-wait memory (k=1), the minimum request-to-ready latency is 2 cycles and back-to-back accesses complete every 3 cycles.
- Timeout:
  - tcnt increments every busy cycle with mem_ready=0.
  - When tcnt reaches TIMEOUT-1 with mem_ready still 0, the access is aborted: mem_req goes to 0, the owner's ready pulses with rdata=0, bus_err is set, and state goes to IDLE.
  - bus_err stays 1 until rst.
- mem_ready while mem_req=0 is ignored.
- At most one of if_ready and dm_ready is asserted in any cycle.

Test Plan:
- Reset and single fetch: rst for 2 cycles, then if_req=1, if_addr=0x100, with memory returning 0x00500093 at k=1. Expect mem_req=1, mem_we=0, mem_be=F in cycle 1; if_ready=1 with if_rdata=0x00500093 in cycle 2; no second grant in cycle 2.
- Simultaneous requests: if_req=1 and dm_req=1 (load 0x2000) in the same cycle. Expect DM served first (mem_addr=0x2000), then IF; dm_ready precedes if_ready.
- Starvation bound: MAX_DATA_STREAK=4, if_req held high, DM issuing 6 back-to-back stores. Expect grant order DM,DM,DM,DM,IF,DM,DM, and the streak clears after the IF grant.
- Store with wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, dm_be=0011, mem_ready after 3 cycles. Expect mem_* stable for all 3 cycles, dm_ready a single pulse, dm_rdata=0.
- Timeout: mem_ready never asserted, TIMEOUT=16. Expect mem_req to fall after 16 busy cycles, if_ready to pulse with rdata=0, bus_err=1 and staying 1. A subsequent normal access completes normally.
- Reset mid-access: rst asserted in cycle 2 of a DM access. Expect all outputs 0 on the next edge, no dm_ready pulse, and state IDLE.
